// File: rtl/timer_run_ctrl.sv
// Run/pause/done sequencer for the timer counter: turns button edges into load/count strobes
// and divides clk down to the count tick. Outputs are decoded from registered state only; cnt_en also depends on count.
module timer_run_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 14,
  parameter int MAX_CNT  = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_btn,
  input  logic             clr_btn,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] preset,
  input  logic [CNT_W-1:0] count,
  output logic             ld,
  output logic [CNT_W-1:0] ld_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             done,
  output logic [2:0]       state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MAX_CNT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic             clr_q, clr_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [PW-1:0]    presc_q, presc_d;

  logic             st_rise, cl_rise;
  logic [CNT_W-1:0] preset_clamped;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      clr_q    <= 1'b0;
      mode_q   <= 2'b00;
      pre_q    <= '0;
      target_q <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      clr_q    <= clr_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      target_q <= target_d;
      presc_q  <= presc_d;
    end
  end

  always_comb begin
    st_rise        = start_btn & ~start_q;
    cl_rise        = clr_btn & ~clr_q;
    preset_clamped = (preset > MAX_V) ? MAX_V : preset;

    state_d  = state_q;
    start_d  = start_btn;
    clr_d    = clr_btn;
    mode_d   = mode_q;
    pre_d    = pre_q;
    target_d = target_q;
    presc_d  = presc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cl_rise) begin
          state_d = S_CLEAR;
        end else if (st_rise) begin
          state_d = S_LOAD;
          mode_d  = mode;
          pre_d   = preset_clamped;
        end
      end
      S_LOAD: begin
        case (mode_q)
          2'b00:   target_d = MAX_V;
          2'b10:   target_d = pre_q;
          default: target_d = '0;
        endcase
        presc_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + 1'b1;
        if (cl_rise)              state_d = S_CLEAR;
        else if (count == target_q) state_d = S_DONE;
        else if (st_rise)         state_d = S_PAUSE;
      end
      S_PAUSE: begin
        // prescaler holds so a resumed run finishes the partial tick
        if (cl_rise)      state_d = S_CLEAR;
        else if (st_rise) state_d = S_RUN;
      end
      S_CLEAR: begin
        presc_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    done   = 1'b0;
    cnt_en = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld = 1'b1;
        case (mode_q)
          2'b01:   ld_val = MAX_V;
          2'b11:   ld_val = pre_q;
          default: ld_val = '0;
        endcase
      end
      S_RUN:   cnt_en = (presc_q == PRESC_TOP) && (count != target_q);
      S_DONE:  done = 1'b1;
      S_CLEAR: ld = 1'b1;
      default: ;
    endcase
    state  = state_q;
    cnt_up = ~mode_q[0];
  end

endmodule
